// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light monitor: FSM phases, cur_phase encodings
// and the decoded lamp-pattern classes.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALLRED = 3'd1,
        NS_GO  = 3'd2,
        EW_GO  = 3'd3,
        FAULT  = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        PAT_NSG    = 2'd0,
        PAT_EWG    = 2'd1,
        PAT_ALLRED = 2'd2,
        PAT_BAD    = 2'd3
    } pattern_e;

    localparam logic [1:0] CP_IDLE  = 2'b00;
    localparam logic [1:0] CP_NS    = 2'b01;
    localparam logic [1:0] CP_EW    = 2'b10;
    localparam logic [1:0] CP_FAULT = 2'b11;

    // A direction is well-formed only when exactly one of its lamps is lit.
    function automatic pattern_e decode_pattern(
        input logic ns_red,
        input logic ns_green,
        input logic ew_red,
        input logic ew_green
    );
        pattern_e pat;
        if ((ns_green && ew_green) || (ns_red == ns_green) || (ew_red == ew_green)) begin
            pat = PAT_BAD;
        end else if (ns_green) begin
            pat = PAT_NSG;
        end else if (ew_green) begin
            pat = PAT_EWG;
        end else begin
            pat = PAT_ALLRED;
        end
        return pat;
    endfunction

    function automatic logic [1:0] phase_to_cp(input phase_e ph);
        logic [1:0] cp;
        case (ph)
            NS_GO:   cp = CP_NS;
            EW_GO:   cp = CP_EW;
            FAULT:   cp = CP_FAULT;
            default: cp = CP_IDLE;
        endcase
        return cp;
    endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// Saturating dwell counter: load forces 1, inc adds 1 until all-ones.
module tl_dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor on the traffic-light lamp bus: classifies patterns, tracks green
// dwell, flags unsafe patterns (sticky), short/over-long greens and counts green phases.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             NS_red,
    input  logic             NS_green,
    input  logic             EW_red,
    input  logic             EW_green,
    output logic             fault,
    output logic             short_green,
    output logic             stuck_green,
    output logic [CNT_W-1:0] phase_cnt,
    output logic [CNT_W-1:0] last_green_len,
    output logic [1:0]       cur_phase
);

    localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MAX_G = CNT_W'(MAX_GREEN);

    pattern_e         pattern;
    phase_e           state_reg, state_next;
    logic [CNT_W-1:0] dwell;
    logic             dwell_load, dwell_inc;

    logic             in_green, next_green, changing;
    logic             green_exit, green_entry, stuck_hit;

    logic             partial_reg, partial_next;
    logic             fault_reg, fault_next;
    logic             short_green_reg, short_green_next;
    logic             stuck_green_reg, stuck_green_next;
    logic [CNT_W-1:0] phase_cnt_reg, phase_cnt_next;
    logic [CNT_W-1:0] last_green_len_reg, last_green_len_next;
    logic [1:0]       cur_phase_reg, cur_phase_next;

    tl_dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .load  (dwell_load),
        .inc   (dwell_inc),
        .count (dwell)
    );

    always_comb begin
        pattern = decode_pattern(NS_red, NS_green, EW_red, EW_green);

        // FAULT is absorbing; otherwise the next state simply mirrors the pattern.
        state_next = state_reg;
        if (state_reg != FAULT) begin
            case (pattern)
                PAT_BAD: state_next = FAULT;
                PAT_NSG: state_next = NS_GO;
                PAT_EWG: state_next = EW_GO;
                default: state_next = ALLRED;
            endcase
        end

        in_green    = (state_reg == NS_GO) || (state_reg == EW_GO);
        next_green  = (state_next == NS_GO) || (state_next == EW_GO);
        changing    = (state_next != state_reg);
        green_exit  = in_green && changing && (state_next != FAULT);
        green_entry = next_green && changing;
        // dwell is compared before its update, so this fires as it becomes MAX+1.
        stuck_hit   = in_green && !changing && (dwell == MAX_G);

        dwell_load = changing && (state_next != FAULT);
        dwell_inc  = !changing && (state_reg != FAULT);

        partial_next        = partial_reg;
        phase_cnt_next      = phase_cnt_reg;
        last_green_len_next = last_green_len_reg;
        short_green_next    = 1'b0;
        stuck_green_next    = stuck_hit;

        if (green_exit) begin
            last_green_len_next = dwell;
            short_green_next    = (dwell < MIN_G) && !partial_reg;
            partial_next        = 1'b0;
        end
        if (green_entry) begin
            phase_cnt_next = phase_cnt_reg + 1'b1;
        end

        fault_next     = (state_next == FAULT);
        cur_phase_next = phase_to_cp(state_next);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            partial_reg        <= 1'b1;
            fault_reg          <= 1'b0;
            short_green_reg    <= 1'b0;
            stuck_green_reg    <= 1'b0;
            phase_cnt_reg      <= '0;
            last_green_len_reg <= '0;
            cur_phase_reg      <= CP_IDLE;
        end else begin
            state_reg          <= state_next;
            partial_reg        <= partial_next;
            fault_reg          <= fault_next;
            short_green_reg    <= short_green_next;
            stuck_green_reg    <= stuck_green_next;
            phase_cnt_reg      <= phase_cnt_next;
            last_green_len_reg <= last_green_len_next;
            cur_phase_reg      <= cur_phase_next;
        end
    end

    assign fault          = fault_reg;
    assign short_green    = short_green_reg;
    assign stuck_green    = stuck_green_reg;
    assign phase_cnt      = phase_cnt_reg;
    assign last_green_len = last_green_len_reg;
    assign cur_phase      = cur_phase_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: vector table, directed corner sequences and
// random lamp sequences checked against a run-length reference model.
module tb_traffic_light_monitor;

    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 16;
    localparam int CNT_W     = 8;

    // lamp order {NS_red, NS_green, EW_red, EW_green}
    localparam logic [3:0] L_NSG  = 4'b0110;
    localparam logic [3:0] L_EWG  = 4'b1001;
    localparam logic [3:0] L_ALLR = 4'b1010;
    localparam logic [3:0] L_ALL  = 4'b1111;
    localparam logic [3:0] L_NSDK = 4'b0010;

    logic             clk = 1'b0;
    logic             reset;
    logic             ns_red, ns_green, ew_red, ew_green;
    logic             fault, short_green, stuck_green;
    logic [CNT_W-1:0] phase_cnt, last_green_len;
    logic [1:0]       cur_phase;

    traffic_light_monitor #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .NS_red         (ns_red),
        .NS_green       (ns_green),
        .EW_red         (ew_red),
        .EW_green       (ew_green),
        .fault          (fault),
        .short_green    (short_green),
        .stuck_green    (stuck_green),
        .phase_cnt      (phase_cnt),
        .last_green_len (last_green_len),
        .cur_phase      (cur_phase)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int short_seen, stuck_seen;

    // reference model: pattern class (-1 none, 0 NSG, 1 EWG, 2 ALLRED), run length
    int m_pat, m_run, m_fault, m_cnt, m_last, m_partial, m_phase, m_short, m_stuck;

    typedef struct {
        logic [3:0] lamps;
        logic       exp_fault;
        logic [1:0] exp_phase;
        logic       exp_short;
        logic       exp_stuck;
        logic [7:0] exp_cnt;
        logic [7:0] exp_last;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [3:0] l);
        if (!(l[3] ^ l[2]) || !(l[1] ^ l[0]) || (l[2] && l[0])) return 3;
        if (l[2]) return 0;
        if (l[0]) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_pat = -1; m_run = 0; m_fault = 0; m_cnt = 0; m_last = 0;
        m_partial = 1; m_phase = 0; m_short = 0; m_stuck = 0;
    endtask

    task automatic model_step(input int p);
        m_short = 0;
        m_stuck = 0;
        if (m_fault != 0) return;
        if (p == 3) begin
            m_fault = 1;
            m_phase = 3;
            return;
        end
        if (p != m_pat) begin
            if (m_pat == 0 || m_pat == 1) begin
                m_last = (m_run > 255) ? 255 : m_run;
                if (m_run < MIN_GREEN && m_partial == 0) m_short = 1;
                m_partial = 0;
            end
            if (p == 0 || p == 1) m_cnt = (m_cnt + 1) % 256;
            m_run = 1;
        end else begin
            m_run++;
            if ((p == 0 || p == 1) && m_run == MAX_GREEN + 1) m_stuck = 1;
        end
        m_pat   = p;
        m_phase = (p == 0) ? 1 : (p == 1) ? 2 : 0;
    endtask

    task automatic check_model();
        chk("fault",       int'(fault),          m_fault);
        chk("cur_phase",   int'(cur_phase),      m_phase);
        chk("phase_cnt",   int'(phase_cnt),      m_cnt);
        chk("last_len",    int'(last_green_len), m_last);
        chk("short_green", int'(short_green),    m_short);
        chk("stuck_green", int'(stuck_green),    m_stuck);
    endtask

    // Called from the post-edge region: drive on the negedge, check 1 time unit after posedge.
    task automatic step(input logic [3:0] l);
        @(negedge clk);
        {ns_red, ns_green, ew_red, ew_green} = l;
        @(posedge clk);
        #1;
        model_step(classify(l));
        short_seen += int'(short_green);
        stuck_seen += int'(stuck_green);
        $display("t=%0t lamps=%b phase=%0d fault=%0b cnt=%0d last=%0d short=%0b stuck=%0b",
                 $time, l, cur_phase, fault, phase_cnt, last_green_len, short_green, stuck_green);
        check_model();
    endtask

    // Asynchronous assertion is checked before any clock edge arrives.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        chk("rst_fault",     int'(fault),          0);
        chk("rst_phase",     int'(cur_phase),      0);
        chk("rst_phase_cnt", int'(phase_cnt),      0);
        chk("rst_last_len",  int'(last_green_len), 0);
        chk("rst_short",     int'(short_green),    0);
        chk("rst_stuck",     int'(stuck_green),    0);
        model_reset();
        short_seen = 0;
        stuck_seen = 0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        $display("t=%0t reset released after %0d cycles", $time, cycles);
    endtask

    task automatic step_n(input logic [3:0] l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    initial begin
        {ns_red, ns_green, ew_red, ew_green} = L_ALLR;
        reset = 1'b0;
        #2;
        do_reset(2);

        // vector table from a clean reset
        tbl[0] = '{L_ALLR, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[1] = '{L_NSG,  1'b0, 2'd1, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[2] = '{L_NSG,  1'b0, 2'd1, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[3] = '{L_EWG,  1'b0, 2'd2, 1'b0, 1'b0, 8'd2, 8'd2};
        tbl[4] = '{L_EWG,  1'b0, 2'd2, 1'b0, 1'b0, 8'd2, 8'd2};
        tbl[5] = '{L_NSG,  1'b0, 2'd1, 1'b1, 1'b0, 8'd3, 8'd2};
        tbl[6] = '{L_ALLR, 1'b0, 2'd0, 1'b1, 1'b0, 8'd3, 8'd1};
        tbl[7] = '{L_ALLR, 1'b0, 2'd0, 1'b0, 1'b0, 8'd3, 8'd1};
        tbl[8] = '{L_NSDK, 1'b1, 2'd3, 1'b0, 1'b0, 8'd3, 8'd1};
        tbl[9] = '{L_NSG,  1'b1, 2'd3, 1'b0, 1'b0, 8'd3, 8'd1};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].lamps);
            chk("tbl_fault", int'(fault),          int'(tbl[i].exp_fault));
            chk("tbl_phase", int'(cur_phase),      int'(tbl[i].exp_phase));
            chk("tbl_short", int'(short_green),    int'(tbl[i].exp_short));
            chk("tbl_stuck", int'(stuck_green),    int'(tbl[i].exp_stuck));
            chk("tbl_cnt",   int'(phase_cnt),      int'(tbl[i].exp_cnt));
            chk("tbl_last",  int'(last_green_len), int'(tbl[i].exp_last));
        end

        // normal cycle
        do_reset(2);
        step_n(L_NSG, 10); step_n(L_ALLR, 2); step_n(L_EWG, 10); step(L_ALLR);
        chk("t1_cnt",   int'(phase_cnt),      2);
        chk("t1_last",  int'(last_green_len), 10);
        chk("t1_short", short_seen,           0);
        chk("t1_stuck", stuck_seen,           0);
        chk("t1_fault", int'(fault),          0);

        // short green on the first sample after it ends
        do_reset(2);
        step_n(L_NSG, 10); step_n(L_EWG, 3); step(L_NSG);
        chk("t2_short_pulse", int'(short_green),    1);
        chk("t2_last",        int'(last_green_len), 3);
        step(L_NSG);
        chk("t2_short_end",   int'(short_green),    0);
        chk("t2_short_count", short_seen,           1);

        // stuck green on the 17th sample, only once
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            step(L_NSG);
            if (i == 16) chk("t3_stuck_17", int'(stuck_green), 1);
        end
        chk("t3_stuck_count", stuck_seen,        1);
        chk("t3_phase",       int'(cur_phase),   1);

        // all lamps lit: sticky fault, cleared by reset
        do_reset(2);
        step_n(L_NSG, 3); step(L_ALL);
        chk("t4_fault",  int'(fault),     1);
        chk("t4_phase",  int'(cur_phase), 3);
        step_n(L_NSG, 2);
        chk("t4_hold_fault", int'(fault),     1);
        chk("t4_hold_phase", int'(cur_phase), 3);
        do_reset(1);

        // dark NS head: fault, phase_cnt frozen
        step_n(L_NSG, 5); step(L_NSDK);
        chk("t5_fault", int'(fault), 1);
        step_n(L_EWG, 3); step_n(L_NSG, 2);
        chk("t5_cnt", int'(phase_cnt), 1);

        // reset mid-NSG: partial phase is exempt from short_green
        do_reset(1);
        step_n(L_NSG, 4);
        {ns_red, ns_green, ew_red, ew_green} = L_NSG;
        do_reset(3);
        step_n(L_NSG, 2); step(L_EWG);
        chk("t6_short", short_seen,           0);
        chk("t6_cnt",   int'(phase_cnt),      2);
        chk("t6_last",  int'(last_green_len), 2);

        // random segments against the model
        do_reset(2);
        for (int seg = 0; seg < 60; seg++) begin
            int r;
            int len;
            logic [3:0] l;
            r   = int'($urandom_range(0, 39));
            len = int'($urandom_range(1, 20));
            case (r % 3)
                0:       l = L_NSG;
                1:       l = L_EWG;
                default: l = L_ALLR;
            endcase
            if (r == 0) l = 4'($urandom_range(0, 15));
            if (r == 1 || (m_fault != 0 && r < 20)) do_reset(int'($urandom_range(1, 3)));
            step_n(l, len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
